mips_cpu_mem_port: RTL
======================

# mips_cpu_mem_port

Parametrised Avalon-MM master port that sits between the multicycle MIPS core's MEM stage and the memory bus. It replaces the core's fixed word-only, zero-wait bus logic. It adds byte, halfword and word accesses with byte-lane steering, sign/zero extension, full `waitrequest` stalling, misalignment detection and an optional bus-timeout fault. The core issues one request at a time via a valid/ready handshake and receives a single-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `TIMEOUT`, 0, max `waitrequest` cycles before fault; 0 disables timeout.

Ports:
- Clocking and reset: `rst` is synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  port can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word; 3 is illegal and treated as misaligned.
- `req_signed`  in  1  sign-extend load result.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_error`  out  1  qualifies `rsp_valid`: misaligned access or timeout.
- `address`  out  ADDR_W  Avalon address, word-aligned (low 2 bits always 0).
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  slave stall.
- `writedata`  out  32  lane-replicated store data.
- `byteenable`  out  4  active lanes.
- `readdata`  in  32  Avalon read data.

## Operation
- Four-state FSM:
  - IDLE: `req_ready` = 1.
  - BUS: holds `read` or `write`, `address`, `byteenable`, `writedata` constant.
  - RESP: `rsp_valid` = 1.
  - ERR: `rsp_valid` = 1, `rsp_error` = 1.
- Acceptance: occurs on `req_valid && req_ready` at a rising edge. All request fields are registered at that edge; the core may change its inputs afterwards.
- Alignment:
  - half requires `addr[0]` = 0; word requires `addr[1:0]` = 0.
  - A violation goes IDLE→ERR with no bus cycle, then ERR→IDLE.
- Byte lanes, little-endian: lane = `addr[1:0]`.
  - byte: `byteenable` = 0001 shifted left by `addr[1:0]`.
  - half: 0011 or 1100.
  - word: 1111.
- `writedata`:
  - byte: `wdata[7:0]` replicated ×4.
  - half: `wdata[15:0]` replicated ×2.
  - word: `wdata` unchanged.
- BUS exit: occurs on the first edge where `waitrequest` = 0. For loads, the selected lane(s) of `readdata` are captured, shifted to bit 0, and sign- or zero-extended per `req_signed`; the FSM then goes to RESP. RESP→IDLE unconditionally.
- Timeout counter:
  - Cleared on entry to BUS; increments each BUS cycle with `waitrequest` = 1.
  - If `TIMEOUT` > 0 and the count reaches `TIMEOUT`, the FSM goes BUS→ERR and the strobes drop.
  - `waitrequest` falling in the same cycle the count reaches `TIMEOUT` counts as success.
- Reset values: state IDLE; `read` = `write` = 0; `address` = 0; `byteenable` = 0; `writedata` = 0; `rsp_valid` = 0; `rsp_error` = 0; `rsp_rdata` = 0; `req_ready` = 1 in the first cycle after reset.
- Reset during BUS or RESP aborts the access. Strobes are 0 after the reset edge and no response is issued.

## Timing
- All outputs are registered or decoded from state registers only; there are no combinational input→output paths, except that `req_ready` is a pure decode of IDLE.
- Zero-wait load or store: accepted at edge N; BUS during cycle N..N+1; RESP (`rsp_valid` high) in the cycle after edge N+1; next acceptance possible at edge N+3.
- Each `waitrequest` = 1 cycle adds one cycle to BUS.
- Misaligned access: `rsp_valid` + `rsp_error` is high in the cycle after acceptance.
- `rsp_rdata` and `rsp_error` are valid only while `rsp_valid` = 1.

## Structure
- `mips_cpu_pkg` holds the following, shared with the core:
  - the `mem_size_t` enum (BYTE/HALF/WORD);
  - the `mem_port_state_t` enum;
  - the lane-mask constants.
- One sub-module, `mips_cpu_load_align`, is purely combinational:
  - inputs: `readdata`, `addr[1:0]`, size, signed;
  - output: extended 32-bit result.
  - It is reused later by the LWL/LWR path.

## Test plan
- Zero-wait SW: addr 0x1000, wdata 0xDEADBEEF → one BUS cycle with `address` 0x1000, `byteenable` 1111, `writedata` 0xDEADBEEF; `rsp_valid` two cycles after acceptance, `rsp_error` 0.
- LB signed: addr 0x1003, `readdata` 0x80FF_0000 → `byteenable` 1000, `rsp_rdata` 0xFFFFFF80. Same access with LBU → 0x00000080.
- SH: addr 0x2002, wdata 0x0000_1234, 3 cycles of `waitrequest` → `writedata` 0x12341234, `byteenable` 1100, strobes stable for 4 cycles, `rsp_valid` follows.
- LW: addr 0x1001 → `rsp_error` = 1 the next cycle, `read` never asserted; same result for LH addr 0x1001 and for `req_size` = 3.
- `TIMEOUT` = 4, `waitrequest` held high → `read` drops after 4 stalled cycles and `rsp_error` = 1. Second run: `waitrequest` falls on stall 4 → normal RESP.
- `rst` asserted in the 2nd stall cycle of a store → `write` = 0 after the edge, no `rsp_valid`, `req_ready` = 1.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MEM-stage types for the multicycle MIPS core.
// Access sizes, port FSM states and byte-lane helpers.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } mem_port_state_t;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b1;
    unique case (1'b1)
      size == MEM_BYTE: m = 1'b0;
      size == MEM_HALF: m = a[0];
      size == MEM_WORD: m = |a;
      default:          m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == MEM_BYTE: m = LANE_B << a;
      size == MEM_HALF: m = LANE_H << {a[1], 1'b0};
      size == MEM_WORD: m = LANE_W;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(
    input logic [1:0]  size,
    input logic [31:0] w
  );
    logic [31:0] d;
    d = w;
    unique case (1'b1)
      size == MEM_BYTE: d = {4{w[7:0]}};
      size == MEM_HALF: d = {2{w[15:0]}};
      default:          d = w;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load data aligner: picks the addressed lane(s) of a bus word,
// right-justifies and sign/zero extends them.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = readdata[{addr, 3'b000} +: 8];
    h      = addr[1] ? readdata[31:16] : readdata[15:0];
    result = '0;
    unique case (1'b1)
      size == MEM_BYTE: result = {{24{sign_ext & b[7]}}, b};
      size == MEM_HALF: result = {{16{sign_ext & h[15]}}, h};
      size == MEM_WORD: result = readdata;
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_port.sv
// Avalon-MM master for the MEM stage: sized accesses, lane steering,
// waitrequest stalling, misalignment and optional timeout faults.
module mips_cpu_mem_port
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam bit TMO_EN = TIMEOUT > 0;
  localparam logic [31:0] TMO_LAST =
    TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  mem_port_state_t state, state_nx;

  logic        wr_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] cnt;
  logic [31:0] ld_data;
  logic        accept;
  logic        tmo_hit;

  assign accept  = req_valid && req_ready;
  // Current cycle is the TIMEOUT-th stalled one; a released
  // waitrequest takes priority in the next-state logic.
  assign tmo_hit = TMO_EN && (cnt == TMO_LAST);

  mips_cpu_load_align u_align (
    .readdata (readdata),
    .addr     (lane_q),
    .size     (size_q),
    .sign_ext (sgn_q),
    .result   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid)
          state_nx = misaligned(req_size, req_addr[1:0])
                   ? ST_ERR : ST_BUS;
      end
      ST_BUS: begin
        if (!waitrequest)  state_nx = ST_RESP;
        else if (tmo_hit)  state_nx = ST_ERR;
      end
      ST_RESP: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = state == ST_IDLE;
    read      = (state == ST_BUS) && !wr_q;
    write     = (state == ST_BUS) && wr_q;
    rsp_valid = (state == ST_RESP) || (state == ST_ERR);
    rsp_error = state == ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      rsp_rdata  <= '0;
      wr_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= 2'd0;
      lane_q     <= 2'd0;
      cnt        <= '0;
    end else if (accept) begin
      address    <= {req_addr[ADDR_W-1:2], 2'b00};
      byteenable <= lane_mask(req_size, req_addr[1:0]);
      writedata  <= store_lanes(req_size, req_wdata);
      rsp_rdata  <= '0;
      wr_q       <= req_write;
      sgn_q      <= req_signed;
      size_q     <= req_size;
      lane_q     <= req_addr[1:0];
      cnt        <= '0;
    end else if (state == ST_BUS) begin
      if (waitrequest) cnt <= cnt + 32'd1;
      else if (!wr_q)  rsp_rdata <= ld_data;
    end
  end

endmodule
